// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared PWM defaults, FSM states and period helper
// Used by both the PWM generator and pwm_capture so the two ends agree on the
// waveform rule: period = 2^WORD_LENGTH << freq, high time = duty << freq.
package pwm_pkg;

    localparam int DEFAULT_WORD_LENGTH = 8;
    localparam int DEFAULT_FREQ_LENGTH = 2;

    // Longest legal period: the largest frequency code at the default widths.
    localparam int MAX_PERIOD = (2 ** DEFAULT_WORD_LENGTH) << (2 ** DEFAULT_FREQ_LENGTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        HIGH,
        LOW
    } state_t;

    // Period in clocks produced by frequency code k.
    function automatic int period_of(input int k, input int word_length = DEFAULT_WORD_LENGTH);
        return (2 ** word_length) << k;
    endfunction

endpackage

// File: rtl/pwm_input_sync.sv
// rtl/pwm_input_sync.sv - 2-flop synchronizer with edge detection for the PWM line
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   pwm_input      asynchronous PWM line
//   level          synchronized line level
//   rise, fall     single-cycle edge strobes derived from level and its previous value
module pwm_input_sync (
    input  logic clk,
    input  logic reset,
    input  logic pwm_input,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= pwm_input;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~prev;
    assign fall  = ~sync & prev;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - decodes a PWM waveform back into duty cycle and frequency code
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   start        enable; low forces IDLE
//   pwm_input    asynchronous PWM line
//   dutyCycle    last decoded duty cycle
//   frequency    last decoded frequency code
//   valid        one-cycle pulse per decoded period (or 0% duty timeout)
//   locked       level, last measurement was good
//   error        one-cycle pulse on bad period, bad high time or stuck-high line
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH,
    parameter int FREQ_LENGTH = DEFAULT_FREQ_LENGTH,
    parameter int CNT_WIDTH   = WORD_LENGTH + 2 ** FREQ_LENGTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   pwm_input,
    output logic [WORD_LENGTH-1:0] dutyCycle,
    output logic [FREQ_LENGTH-1:0] frequency,
    output logic                   valid,
    output logic                   locked,
    output logic                   error
);

    localparam int NUM_FREQ = 2 ** FREQ_LENGTH;
    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(period_of(NUM_FREQ - 1, WORD_LENGTH));

    logic sync_level;
    logic sync_rise;
    logic sync_fall;

    pwm_input_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .pwm_input (pwm_input),
        .level     (sync_level),
        .rise      (sync_rise),
        .fall      (sync_fall)
    );

    state_t                 state;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [CNT_WIDTH-1:0]   hi_cnt;
    logic [CNT_WIDTH-1:0]   cnt_inc;
    logic                   timeout;

    logic                   k_found;
    logic [FREQ_LENGTH-1:0] k_sel;
    logic [CNT_WIDTH-1:0]   low_mask;
    logic                   decode_ok;
    logic [WORD_LENGTH-1:0] duty_dec;

    // A rise on the same cycle the counter tops out closes a legal
    // MAX_PERIOD waveform, so it wins over the timeout.
    assign cnt_inc = (cnt == MAX_CNT) ? cnt : cnt + CNT_WIDTH'(1);
    assign timeout = (cnt == MAX_CNT) && !sync_rise;

    // Period P = cnt and high time H = hi_cnt at the closing rise.
    always_comb begin
        k_found = 1'b0;
        k_sel   = '0;
        for (int k = 0; k < NUM_FREQ; k++) begin
            if (cnt == CNT_WIDTH'(period_of(k, WORD_LENGTH))) begin
                k_found = 1'b1;
                k_sel   = FREQ_LENGTH'(k);
            end
        end
        low_mask  = (CNT_WIDTH'(1) << k_sel) - CNT_WIDTH'(1);
        decode_ok = k_found && ((hi_cnt & low_mask) == '0) && (hi_cnt < cnt);
        duty_dec  = WORD_LENGTH'(hi_cnt >> k_sel);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            hi_cnt    <= '0;
            dutyCycle <= '0;
            frequency <= '0;
            valid     <= 1'b0;
            locked    <= 1'b0;
            error     <= 1'b0;
        end else begin
            valid <= 1'b0;
            error <= 1'b0;
            if (!start) begin
                state  <= IDLE;
                cnt    <= '0;
                hi_cnt <= '0;
                locked <= 1'b0;
            end else if (state != IDLE && timeout) begin
                // No rise for a whole MAX_PERIOD: the line is stuck.
                cnt   <= CNT_WIDTH'(1);
                state <= SYNC;
                if (sync_level) begin
                    error  <= 1'b1;
                    locked <= 1'b0;
                end else begin
                    valid     <= 1'b1;
                    dutyCycle <= '0;
                    locked    <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        cnt    <= '0;
                        hi_cnt <= '0;
                        locked <= 1'b0;
                        state  <= SYNC;
                    end
                    SYNC: begin
                        if (sync_rise) begin
                            cnt   <= CNT_WIDTH'(1);
                            state <= HIGH;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    HIGH: begin
                        if (sync_rise) begin
                            // Second rise without a fall in between.
                            error  <= 1'b1;
                            locked <= 1'b0;
                            cnt    <= CNT_WIDTH'(1);
                        end else begin
                            cnt <= cnt_inc;
                            if (sync_fall) begin
                                hi_cnt <= cnt;
                                state  <= LOW;
                            end
                        end
                    end
                    LOW: begin
                        if (sync_rise) begin
                            cnt   <= CNT_WIDTH'(1);
                            state <= HIGH;
                            if (decode_ok) begin
                                valid     <= 1'b1;
                                dutyCycle <= duty_dec;
                                frequency <= k_sel;
                                locked    <= 1'b1;
                            end else begin
                                error  <= 1'b1;
                                locked <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

- Receive-side counterpart of the `PWM` generator: it samples a PWM waveform and recovers the `dutyCycle` and `frequency` settings that produced it.
- Decoding follows the generator's waveform rule: period = 2^WORD_LENGTH << frequency clocks, and high time = dutyCycle << frequency clocks.
- It sits on the far end of a PWM line, for loopback self-test and for decoding externally driven PWM commands.

## Interface
Parameters:
- WORD_LENGTH, 8, width of recovered duty cycle
- FREQ_LENGTH, 2, width of recovered frequency code
- CNT_WIDTH, WORD_LENGTH + 2**FREQ_LENGTH, counter width (12 at defaults; holds MAX_PERIOD = 2**WORD_LENGTH << (2**FREQ_LENGTH - 1) = 2048)

Ports:
- clk  input  1  single system clock, rising edge
- reset  input  1  synchronous, active-high
- start  input  1  enable; 0 forces IDLE
- pwm_input  input  1  asynchronous PWM line
- dutyCycle  output  WORD_LENGTH  last decoded duty cycle
- frequency  output  FREQ_LENGTH  last decoded frequency code
- valid  output  1  one-cycle pulse per decoded period
- locked  output  1  level, decoder has a good measurement
- error  output  1  one-cycle pulse on bad period, bad high time, or stuck-high line

## Operation
- **Input path:** pwm_input passes through a 2-flop synchronizer, then a previous-value register.
  - rise = sync & !prev
  - fall = !sync & prev
- **Counter:** cnt (CNT_WIDTH bits, saturates at MAX_PERIOD).
  - Loaded to 1 on rise, increments otherwise.
  - hi_cnt captures cnt on fall.
- **IDLE:** counters cleared, locked = 0, outputs hold. Go to SYNC when start = 1.
- **SYNC:** wait for rise, which starts the count, then go to HIGH.
- **HIGH:** on fall, capture hi_cnt and go to LOW.
- **LOW:** on rise, evaluate period P = cnt and high time H = hi_cnt, then go to HIGH with a new count. A rise seen while in HIGH (a fall was missed) is an error; go to HIGH.
- **Evaluation:** find k with P == 2^WORD_LENGTH << k, for k in 0 to 2^FREQ_LENGTH-1.
  - If k exists, H[k-1:0] == 0, and H < P: register dutyCycle = H >> k and frequency = k, pulse valid, set locked.
  - Otherwise pulse error, clear locked, and hold dutyCycle/frequency.
- **Timeout:** cnt reaches MAX_PERIOD in any of SYNC, HIGH or LOW without a rise.
  - Synchronized line low: dutyCycle = 0, frequency held, pulse valid, locked = 1 (0% duty).
  - Synchronized line high: pulse error, locked = 0.
  - Either case: cnt reloads to 1, state goes to SYNC, and the timeout repeats every MAX_PERIOD cycles while the line stays stuck.
- **start low mid-operation:** IDLE on the next edge; valid/error suppressed that cycle; dutyCycle/frequency hold.
- **Simultaneous events:** start = 0 outranks rise and timeout; rise outranks timeout on the same cycle.

## Timing
- **Reset:** dutyCycle = 0, frequency = 0, valid = 0, locked = 0, error = 0, state IDLE, synchronizer flops 0.
- **Latency:** if pwm_input is first sampled high at edge N, rise is combinationally true in the cycle after edge N+1. The decode registers at edge N+2, so valid/error are high for the one cycle following edge N+2.
  - Total latency is 3 clocks from the sampling edge of the closing rising edge.
  - dutyCycle/frequency update on the same edge valid rises.
- **Measurement span:** the first decode happens after one full period following the first rise in SYNC. Worst case from start to first valid is 2 × MAX_PERIOD + 3 cycles.
- **Exclusivity:** valid and error are never high together. Neither is high in two consecutive cycles, except timeout pulses separated by MAX_PERIOD.
- **Input constraint:** minimum pulse width on pwm_input is 2 clocks; narrower pulses may be missed and produce error.

## Structure
- **Shared package pwm_pkg** (also used by `PWM`):
  - WORD_LENGTH and FREQ_LENGTH defaults
  - state enum (IDLE, SYNC, HIGH, LOW)
  - constant function period_of(k) = 2**WORD_LENGTH << k
  - MAX_PERIOD
- **Sub-module pwm_input_sync:** 2-flop synchronizer plus prev register. Outputs level, rise and fall; synchronous reset.
- **Top:** FSM, counter, evaluation logic and output registers live in pwm_capture.

## Test plan
- **Basic decode:** reset 50 ns, start = 1, drive 8 high / 248 low clocks repeatedly → from the second rise on, valid every 256 cycles with dutyCycle = 8, frequency = 0, locked = 1.
- **Loopback:** `PWM` with dutyCycle = 8'b00001000, frequency = 2'b01 feeds pwm_input → valid every 512 cycles with dutyCycle = 8, frequency = 1. Also sweep frequency 0 to 3 at duty 255 (high 255<<k, low 1<<k) → exact recovery of each setting.
- **Bad waveforms:**
  - Period 300 → error pulse, locked = 0, outputs hold previous values.
  - Period 512 with high time 17 → error (odd high time at k = 1).
- **Stuck line:**
  - Held low → valid with dutyCycle = 0 every 2048 cycles.
  - Held high → error every 2048 cycles, locked = 0.
- **start low mid-period:** start = 0 during HIGH → IDLE next cycle, locked = 0, no valid. Re-assert → re-sync, first valid one full period after the next rise.
- **Synchronous reset mid-measurement:** reset = 1 for one cycle during LOW → all outputs 0 on the next edge. Decoding resumes normally afterwards.
